// File: rtl/sw_debounce.sv
// Switch input conditioning: 2-FF synchroniser, per-channel stability
// filter, and registered rise/fall/any_change edge pulses.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - synchronous active-high reset
//   sw_in      - raw, asynchronous, possibly bouncing switch levels
//   sw_out     - debounced level per channel (registered)
//   rise       - one-cycle pulse when sw_out[i] goes 0->1 (registered)
//   fall       - one-cycle pulse when sw_out[i] goes 1->0 (registered)
//   any_change - OR of all rise and fall bits (registered)
module sw_debounce #(
    parameter int WIDTH         = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    // Count value at which a pending change is accepted.
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0]         s1;
    logic [WIDTH-1:0]         s2;
    logic [WIDTH-1:0][CW-1:0] cnt;
    logic [WIDTH-1:0][CW-1:0] cnt_d;
    logic [WIDTH-1:0]         out_d;
    logic [WIDTH-1:0]         rise_d;
    logic [WIDTH-1:0]         fall_d;

    // A channel counts only while s2 differs from the accepted level;
    // any agreement drops the count back to 0, discarding progress.
    always_comb begin
        cnt_d  = '0;
        out_d  = sw_out;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] != sw_out[i]) begin
                if (cnt[i] == LAST) begin
                    out_d[i]  = s2[i];
                    rise_d[i] = s2[i];
                    fall_d[i] = ~s2[i];
                end else begin
                    cnt_d[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= '0;
            s2         <= '0;
            cnt        <= '0;
            sw_out     <= '0;
            rise       <= '0;
            fall       <= '0;
            any_change <= 1'b0;
        end else begin
            s1         <= sw_in;
            s2         <= s1;
            cnt        <= cnt_d;
            sw_out     <= out_d;
            rise       <= rise_d;
            fall       <= fall_d;
            any_change <= |(rise_d | fall_d);
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed testbench for sw_debounce (WIDTH=2, STABLE_CYCLES=4).
// Observed vector per cycle is {sw_out, rise, fall, any_change}.
module tb_sw_debounce;

    logic       clk;
    logic       rst;
    logic [1:0] sw_in;
    logic [1:0] sw_out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       any_change;

    int total;
    int bad;

    sw_debounce #(
        .WIDTH(2),
        .STABLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_in(sw_in),
        .sw_out(sw_out),
        .rise(rise),
        .fall(fall),
        .any_change(any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] v);
        rst   = 1'b1;
        sw_in = v;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst   = 1'b1;
        sw_in = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if ({sw_out, rise, fall, any_change} !== 7'd0) begin
                bad++;
                $display("FAIL reset_hold c=%0d got=%b exp=%b", c,
                         {sw_out, rise, fall, any_change}, 7'd0);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 6)     exp = 7'b11_11_00_1;
            else if (e > 6) exp = 7'b11_00_00_0;
            else            exp = 7'b00_00_00_0;
            total++;
            if ({sw_out, rise, fall, any_change} !== exp) begin
                bad++;
                $display("FAIL reset_release e=%0d got=%b exp=%b", e,
                         {sw_out, rise, fall, any_change}, exp);
            end
        end
    endtask

    task automatic test_clean_step();
        logic [6:0] exp;
        do_reset(2'b00);
        sw_in = 2'b01;
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e == 5)     exp = 7'b01_01_00_1;
            else if (e > 5) exp = 7'b01_00_00_0;
            else            exp = 7'b00_00_00_0;
            total++;
            if ({sw_out, rise, fall, any_change} !== exp) begin
                bad++;
                $display("FAIL clean_rise e=%0d got=%b exp=%b", e,
                         {sw_out, rise, fall, any_change}, exp);
            end
        end
        sw_in = 2'b00;
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e == 5)     exp = 7'b00_00_01_1;
            else if (e > 5) exp = 7'b00_00_00_0;
            else            exp = 7'b01_00_00_0;
            total++;
            if ({sw_out, rise, fall, any_change} !== exp) begin
                bad++;
                $display("FAIL clean_fall e=%0d got=%b exp=%b", e,
                         {sw_out, rise, fall, any_change}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [6:0] exp;
        do_reset(2'b00);
        // 3-cycle excursion: must be rejected
        for (int e = 0; e <= 9; e++) begin
            sw_in = (e < 3) ? 2'b01 : 2'b00;
            tick();
            total++;
            if ({sw_out, rise, fall, any_change} !== 7'd0) begin
                bad++;
                $display("FAIL glitch3 e=%0d got=%b exp=%b", e,
                         {sw_out, rise, fall, any_change}, 7'd0);
            end
        end
        // 4-cycle excursion: accepted, then released 4 cycles later
        for (int e = 0; e <= 11; e++) begin
            sw_in = (e < 4) ? 2'b01 : 2'b00;
            tick();
            if (e == 5)               exp = 7'b01_01_00_1;
            else if (e > 5 && e < 9)  exp = 7'b01_00_00_0;
            else if (e == 9)          exp = 7'b00_00_01_1;
            else                      exp = 7'b00_00_00_0;
            total++;
            if ({sw_out, rise, fall, any_change} !== exp) begin
                bad++;
                $display("FAIL pulse4 e=%0d got=%b exp=%b", e,
                         {sw_out, rise, fall, any_change}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [6:0] exp;
        logic [5:0] pat;
        // applied order 1,0,1,1,0,1 (pat[0] first), then held 1
        pat = 6'b101101;
        do_reset(2'b00);
        for (int e = 0; e <= 13; e++) begin
            sw_in = {(e < 6) ? pat[e] : 1'b1, 1'b0};
            tick();
            if (e == 10)     exp = 7'b10_10_00_1;
            else if (e > 10) exp = 7'b10_00_00_0;
            else             exp = 7'b00_00_00_0;
            total++;
            if ({sw_out, rise, fall, any_change} !== exp) begin
                bad++;
                $display("FAIL bounce e=%0d got=%b exp=%b", e,
                         {sw_out, rise, fall, any_change}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        logic [6:0] exp;
        do_reset(2'b00);
        sw_in = 2'b01;
        for (int e = 0; e <= 3; e++) begin
            tick();
            total++;
            if ({sw_out, rise, fall, any_change} !== 7'd0) begin
                bad++;
                $display("FAIL midcnt_pre e=%0d got=%b exp=%b", e,
                         {sw_out, rise, fall, any_change}, 7'd0);
            end
        end
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if ({sw_out, rise, fall, any_change} !== 7'd0) begin
                bad++;
                $display("FAIL midcnt_rst c=%0d got=%b exp=%b", c,
                         {sw_out, rise, fall, any_change}, 7'd0);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 6)     exp = 7'b01_01_00_1;
            else if (e > 6) exp = 7'b01_00_00_0;
            else            exp = 7'b00_00_00_0;
            total++;
            if ({sw_out, rise, fall, any_change} !== exp) begin
                bad++;
                $display("FAIL midcnt_post e=%0d got=%b exp=%b", e,
                         {sw_out, rise, fall, any_change}, exp);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [6:0] exp;
        do_reset(2'b10);
        for (int c = 0; c < 8; c++) tick();
        total++;
        if ({sw_out, rise, fall, any_change} !== 7'b10_00_00_0) begin
            bad++;
            $display("FAIL simul_settle got=%b exp=%b",
                     {sw_out, rise, fall, any_change}, 7'b10_00_00_0);
        end
        sw_in = 2'b01;
        for (int e = 0; e <= 7; e++) begin
            tick();
            if (e == 5)     exp = 7'b01_01_10_1;
            else if (e > 5) exp = 7'b01_00_00_0;
            else            exp = 7'b10_00_00_0;
            total++;
            if ({sw_out, rise, fall, any_change} !== exp) begin
                bad++;
                $display("FAIL simul e=%0d got=%b exp=%b", e,
                         {sw_out, rise, fall, any_change}, exp);
            end
            total++;
            if ((rise & fall) !== 2'b00) begin
                bad++;
                $display("FAIL simul_excl e=%0d got=%b exp=%b", e,
                         rise & fall, 2'b00);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        sw_in = 2'b00;
        test_reset();
        test_clean_step();
        test_glitch();
        test_bounce();
        test_reset_mid_count();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input conditioning stage between the NVBoard/FPGA switch pins and the `top` XOR datapath. It synchronises `WIDTH` asynchronous switch inputs into `clk`, filters contact bounce with a per-channel stability counter, and presents clean levels plus single-cycle edge pulses. In the default integration, `sw_out[0]` drives `top.a` and `sw_out[1]` drives `top.b`.

## Interface
- `WIDTH`, default 2: number of independent switch channels, ≥1.
- `STABLE_CYCLES`, default 4: number of consecutive synchronised cycles a new level must hold before it is accepted, ≥1.
- `CW`, derived as `$clog2(STABLE_CYCLES+1)`: width of each channel counter.

Ports (reset is synchronous and active-high; one clock):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-high reset, sampled on `clk` rise.
- `sw_in`  in  WIDTH  raw switch levels, asynchronous to `clk`, may bounce.
- `sw_out`  out  WIDTH  debounced level per channel, registered.
- `rise`  out  WIDTH  one-cycle pulse when `sw_out[i]` goes 0→1, registered.
- `fall`  out  WIDTH  one-cycle pulse when `sw_out[i]` goes 1→0, registered.
- `any_change`  out  1  OR of `rise` and `fall`, registered.

## Operation
- Synchroniser: 2-FF chain per channel (`s1 <= sw_in`, `s2 <= s1`). `s2` is the filtered input.
- Per-channel counter `cnt[i]`, width CW:
  - If `s2[i] == sw_out[i]`: `cnt[i] <= 0` and no pulse is generated.
  - If they differ and `cnt[i] < STABLE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - If they differ and `cnt[i] == STABLE_CYCLES-1`: `sw_out[i] <= s2[i]`, `cnt[i] <= 0`, and `rise[i]` or `fall[i]` is set to 1 for that cycle according to the new value.
- Any return of `s2[i]` to the current `sw_out[i]` before acceptance discards progress. Counting restarts from 0 on the next difference.
- Channels are fully independent. Several channels may accept in the same cycle, and each raises its own pulse.
- `rise`/`fall` default to 0 every cycle unless set by an acceptance. `rise[i]` and `fall[i]` are never 1 together.
- The counter never exceeds `STABLE_CYCLES-1`; there is no wrap-around.
- With `STABLE_CYCLES == 1`, a value is accepted on the first differing cycle of `s2`, so the stage is just synchroniser plus edge detect.

## Timing
- Reset: `rst=1` at an edge clears `s1`, `s2`, `cnt`, `sw_out`, `rise`, `fall`, and `any_change` to 0. It takes priority over all other updates.
- Reset mid-count drops the pending change. After release, a held-high input is re-accepted from scratch: it needs the full latency, and `rise` pulses then.
- Latency, with `sw_in` changing before edge E0 and then held:
  - `s1` updates at E0.
  - `s2` updates at E1.
  - `sw_out`, `rise`/`fall`, and `any_change` update at edge E(1+STABLE_CYCLES).
  - Total: `STABLE_CYCLES+2` edges. The default is 6.
- Pulse width is exactly one `clk` cycle. Pulses are aligned with the `sw_out` update.
- Rejection: any `s2` excursion shorter than `STABLE_CYCLES` cycles produces no output change and no pulse.
- Throughput: after an acceptance, a reverse change needs another full `STABLE_CYCLES` of stable `s2`. The minimum spacing between pulses on one channel is therefore `STABLE_CYCLES` cycles.
- No combinational path from `sw_in` to any output.

## Test plan
All scenarios use `STABLE_CYCLES=4`, `WIDTH=2`.
1. **Reset:** hold `rst` 3 cycles with `sw_in=2'b11` → all outputs 0 throughout. After release, `sw_out=2'b11` at the 6th edge after release, with `rise=2'b11` for exactly that one cycle.
2. **Clean step:** `sw_in[0]` 0→1 before E0 → `sw_out[0]=1` and `rise[0]=1` at E5 (one cycle only), `any_change=1` at E5. Then 1→0 → `fall[0]` pulses exactly 6 edges after the change.
3. **Glitch rejection:** `sw_in[0]` high for 3 cycles, then low → `sw_out[0]` stays 0, no `rise`/`fall`. A 4-cycle pulse → accepted: `rise[0]` pulses, then `fall[0]` 4 cycles later.
4. **Bounce:** `sw_in[1]` pattern 1,0,1,1,0,1, then held 1 → exactly one `rise[1]`, asserted 6 edges after the final 0→1 transition.
5. **Reset mid-count:** start a 0→1 change, assert `rst` 2 cycles into counting → no pulse, `cnt` cleared. Input still high → accepted 6 edges after `rst` deasserts.
6. **Simultaneous channels:** both bits change in the same cycle (0→1 on ch0, 1→0 on ch1 from a settled 2'b10) → `rise=2'b01` and `fall=2'b10` in the same cycle, `sw_out=2'b01`; `rise` and `fall` never set on one channel together.
